// File: rtl/atom_rvcore_lsu_pkg.sv
// Shared types and lane constants for the atom rvcore load/store unit.
// Word size is fixed at 32 bits, i.e. four byte lanes.
package atom_rvcore_lsu_pkg;

    localparam int LANES = 4;

    typedef enum logic [2:0] {
        SIZE_B  = 3'b000,
        SIZE_H  = 3'b001,
        SIZE_W  = 3'b010,
        SIZE_BU = 3'b100,
        SIZE_HU = 3'b101
    } size_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_e;

    localparam logic [LANES-1:0] LANE_MASK_B = 4'b0001;
    localparam logic [LANES-1:0] LANE_MASK_H = 4'b0011;
    localparam logic [LANES-1:0] LANE_MASK_W = 4'b1111;

    // Byte lanes touched by an access of the given size at the given byte offset.
    function automatic logic [LANES-1:0] lane_mask(input size_e size, input logic [1:0] off);
        logic [LANES-1:0] m;
        case (size)
            SIZE_B, SIZE_BU: m = LANE_MASK_B << off;
            SIZE_H, SIZE_HU: m = LANE_MASK_H << off;
            default:         m = LANE_MASK_W;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/atom_rvcore_lsu_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge
// and the legality check for one memory operation.
module atom_rvcore_lsu_align
    import atom_rvcore_lsu_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 is_store,
    input  logic [2:0]           funct3,
    input  logic [1:0]           byte_off,
    input  logic [DATAWIDTH-1:0] rdata,
    input  logic [DATAWIDTH-1:0] wdata,
    output logic                 legal,
    output logic [DATAWIDTH-1:0] load_data,
    output logic [DATAWIDTH-1:0] merge_data
);

    size_e                size;
    logic [DATAWIDTH-1:0] shifted;
    logic [DATAWIDTH-1:0] wrep;
    logic [LANES-1:0]     mask;

    assign size = size_e'(funct3);

    always_comb begin
        legal = 1'b0;
        case (size)
            SIZE_B:  legal = 1'b1;
            SIZE_BU: legal = !is_store;
            SIZE_H:  legal = !byte_off[0];
            SIZE_HU: legal = !byte_off[0] && !is_store;
            SIZE_W:  legal = (byte_off == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend.
    assign shifted = rdata >> {byte_off, 3'b000};

    always_comb begin
        load_data = shifted;
        case (size)
            SIZE_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            SIZE_BU: load_data = {24'h0, shifted[7:0]};
            SIZE_H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            SIZE_HU: load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Replicate store data across lanes so the mask alone picks the target bytes.
    always_comb begin
        wrep = wdata;
        case (size)
            SIZE_B:  wrep = {4{wdata[7:0]}};
            SIZE_H:  wrep = {2{wdata[15:0]}};
            default: wrep = wdata;
        endcase
    end

    assign mask = lane_mask(size, byte_off);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign merge_data[8*k +: 8] = mask[k] ? wrep[8*k +: 8] : rdata[8*k +: 8];
    end

endmodule

// File: rtl/atom_rvcore_lsu.sv
// Load/store unit in front of the DCCM word port. Sub-word stores run as a
// two-cycle read-modify-write; loads and faults are registered toward writeback.
module atom_rvcore_lsu
    import atom_rvcore_lsu_pkg::*;
#(
    parameter int DATAWIDTH        = 32,
    parameter int REG_ADRESS_WIDTH = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic                        is_store_i,
    input  logic [2:0]                  funct3_i,
    input  logic [DATAWIDTH-1:0]        addr_i,
    input  logic [DATAWIDTH-1:0]        wdata_i,
    input  logic [REG_ADRESS_WIDTH-1:0] rd_i,
    output logic [DATAWIDTH-1:0]        dccm_addr_o,
    output logic                        dccm_rd_en_o,
    output logic                        dccm_wr_en_o,
    output logic [DATAWIDTH-1:0]        dccm_wdata_o,
    input  logic [DATAWIDTH-1:0]        dccm_rdata_i,
    output logic                        wb_we_o,
    output logic [REG_ADRESS_WIDTH-1:0] wb_rd_o,
    output logic [DATAWIDTH-1:0]        wb_data_o,
    output logic                        fault_o,
    output logic [DATAWIDTH-1:0]        fault_addr_o
);

    state_e               state;
    logic [DATAWIDTH-1:0] merge_addr;
    logic [DATAWIDTH-1:0] merge_data;
    logic                 accept;
    logic                 legal;
    logic                 is_word;
    logic [DATAWIDTH-1:0] word_addr;
    logic [DATAWIDTH-1:0] load_data;
    logic [DATAWIDTH-1:0] merged_word;

    assign ready_o   = (state == ST_IDLE);
    assign accept    = valid_i && ready_o;
    assign is_word   = (size_e'(funct3_i) == SIZE_W);
    assign word_addr = {addr_i[DATAWIDTH-1:2], 2'b00};

    atom_rvcore_lsu_align #(
        .DATAWIDTH (DATAWIDTH)
    ) u_align (
        .is_store   (is_store_i),
        .funct3     (funct3_i),
        .byte_off   (addr_i[1:0]),
        .rdata      (dccm_rdata_i),
        .wdata      (wdata_i),
        .legal      (legal),
        .load_data  (load_data),
        .merge_data (merged_word)
    );

    // IDLE drives the port straight from the request; MERGE replays the held write.
    always_comb begin
        dccm_addr_o  = word_addr;
        dccm_wdata_o = wdata_i;
        dccm_rd_en_o = 1'b0;
        dccm_wr_en_o = 1'b0;
        if (state == ST_MERGE) begin
            dccm_addr_o  = merge_addr;
            dccm_wdata_o = merge_data;
            dccm_wr_en_o = 1'b1;
        end else if (accept && legal) begin
            if (is_store_i && is_word) dccm_wr_en_o = 1'b1;
            else                       dccm_rd_en_o = 1'b1;
        end
        if (!rst_ni) begin
            dccm_rd_en_o = 1'b0;
            dccm_wr_en_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            merge_addr   <= '0;
            merge_data   <= '0;
            wb_we_o      <= 1'b0;
            wb_rd_o      <= '0;
            wb_data_o    <= '0;
            fault_o      <= 1'b0;
            fault_addr_o <= '0;
        end else begin
            wb_we_o <= 1'b0;
            fault_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!legal) begin
                            fault_o      <= 1'b1;
                            fault_addr_o <= addr_i;
                        end else if (!is_store_i) begin
                            wb_we_o   <= 1'b1;
                            wb_rd_o   <= rd_i;
                            wb_data_o <= load_data;
                        end else if (!is_word) begin
                            merge_addr <= word_addr;
                            merge_data <= merged_word;
                            state      <= ST_MERGE;
                        end
                    end
                end
                ST_MERGE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atom_rvcore_lsu.sv
// Scoreboard bench for atom_rvcore_lsu with a behavioural DCCM and a shadow memory model.
module tb_atom_rvcore_lsu;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        is_store_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [4:0]  rd_i = '0;
    logic [31:0] dccm_addr_o;
    logic        dccm_rd_en_o;
    logic        dccm_wr_en_o;
    logic [31:0] dccm_wdata_o;
    logic [31:0] dccm_rdata_i;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        fault_o;
    logic [31:0] fault_addr_o;

    atom_rvcore_lsu #(.DATAWIDTH(32), .REG_ADRESS_WIDTH(5)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .is_store_i   (is_store_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rd_i         (rd_i),
        .dccm_addr_o  (dccm_addr_o),
        .dccm_rd_en_o (dccm_rd_en_o),
        .dccm_wr_en_o (dccm_wr_en_o),
        .dccm_wdata_o (dccm_wdata_o),
        .dccm_rdata_i (dccm_rdata_i),
        .wb_we_o      (wb_we_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .fault_o      (fault_o),
        .fault_addr_o (fault_addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        is_fault;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] dccm[256];
    logic [31:0] ref_mem[256];

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'h8899AABB;
        return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // Behavioural DCCM: combinational read, write on the clock edge.
    assign dccm_rdata_i = dccm[dccm_addr_o[9:2]];
    initial begin
        for (int i = 0; i < 256; i++) dccm[i] = init_word(i);
        forever begin
            @(posedge clk_i);
            if (dccm_wr_en_o) dccm[dccm_addr_o[9:2]] <= dccm_wdata_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic legal_op(input logic st, input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  return 1'b1;
            3'b100:  return !st;
            3'b001:  return !off[0];
            3'b101:  return !st && !off[0];
            3'b010:  return off == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] s;
        s = word >> (8 * int'(off));
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] m;
        m = (f3 == 3'b000 ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * int'(off));
        return (word & ~m) | ((wd << (8 * int'(off))) & m);
    endfunction

    // Writeback/fault monitor: every output pulse must match the oldest expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni && (wb_we_o || fault_o)) begin
            if (sb_q.size() == 0) begin
                chk("spurious_out", {30'b0, wb_we_o, fault_o}, 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("wb_we", 32'(wb_we_o), 32'(!e.is_fault));
                chk("fault", 32'(fault_o), 32'(e.is_fault));
                if (e.is_fault) begin
                    chk("fault_addr", fault_addr_o, e.data);
                end else begin
                    chk("wb_rd", 32'(wb_rd_o), 32'(e.rd));
                    chk("wb_data", wb_data_o, e.data);
                end
            end
        end
    end

    // Drives one operation, checks the DCCM port in the accept cycle (and the
    // MERGE cycle for sub-word stores), and records the expected writeback.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input string tag);
        logic        ok;
        logic [31:0] nw;
        exp_t        e;
        int          idx;
        int          waits;
        ok  = legal_op(st, f3, a[1:0]);
        idx = int'(a[9:2]);
        nw  = ref_mem[idx];
        valid_i = 1'b1; is_store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd; rd_i = rd;
        @(negedge clk_i);
        waits = 0;
        while (!ready_o && waits < 8) begin
            waits++;
            @(negedge clk_i);
        end
        chk({tag, "_stall"}, 32'(waits), 32'h0);
        if (!ok) begin
            chk({tag, "_rd_en"}, 32'(dccm_rd_en_o), 32'h0);
            chk({tag, "_wr_en"}, 32'(dccm_wr_en_o), 32'h0);
            e = '{1'b1, 5'd0, a};
            sb_q.push_back(e);
        end else begin
            chk({tag, "_daddr"}, dccm_addr_o, {a[31:2], 2'b00});
            if (!st) begin
                chk({tag, "_rd_en"}, 32'(dccm_rd_en_o), 32'h1);
                chk({tag, "_wr_en"}, 32'(dccm_wr_en_o), 32'h0);
                e = '{1'b0, rd, ref_load(f3, a[1:0], ref_mem[idx])};
                sb_q.push_back(e);
            end else if (f3 == 3'b010) begin
                chk({tag, "_wr_en"}, 32'(dccm_wr_en_o), 32'h1);
                chk({tag, "_wdata"}, dccm_wdata_o, wd);
                ref_mem[idx] = wd;
            end else begin
                chk({tag, "_rd_en"}, 32'(dccm_rd_en_o), 32'h1);
                chk({tag, "_wr_en"}, 32'(dccm_wr_en_o), 32'h0);
                nw = ref_store(f3, a[1:0], ref_mem[idx], wd);
                ref_mem[idx] = nw;
            end
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        if (ok && st && f3 != 3'b010) begin
            // A request presented during MERGE must be ignored.
            valid_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h100; rd_i = 5'd31;
            @(negedge clk_i);
            chk({tag, "_mrg_ready"}, 32'(ready_o), 32'h0);
            chk({tag, "_mrg_wr_en"}, 32'(dccm_wr_en_o), 32'h1);
            chk({tag, "_mrg_rd_en"}, 32'(dccm_rd_en_o), 32'h0);
            chk({tag, "_mrg_addr"}, dccm_addr_o, {a[31:2], 2'b00});
            chk({tag, "_mrg_wdata"}, dccm_wdata_o, nw);
            valid_i = 1'b0;
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Reset state, with a load presented to prove the enables are held off.
        valid_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h100; rd_i = 5'd9;
        repeat (2) @(negedge clk_i);
        chk("rst_wb_we", 32'(wb_we_o), 32'h0);
        chk("rst_wb_rd", 32'(wb_rd_o), 32'h0);
        chk("rst_wb_data", wb_data_o, 32'h0);
        chk("rst_fault", 32'(fault_o), 32'h0);
        chk("rst_fault_addr", fault_addr_o, 32'h0);
        chk("rst_rd_en", 32'(dccm_rd_en_o), 32'h0);
        chk("rst_wr_en", 32'(dccm_wr_en_o), 32'h0);
        valid_i = 1'b0;
        rst_ni  = 1'b1;
        @(negedge clk_i);
        chk("rst_ready", 32'(ready_o), 32'h1);
        @(posedge clk_i); #1;

        // Loads with extension, back to back.
        issue(1'b0, 3'b000, 32'h103, 32'h0, 5'd1, "lb");
        issue(1'b0, 3'b100, 32'h103, 32'h0, 5'd2, "lbu");
        issue(1'b0, 3'b001, 32'h100, 32'h0, 5'd3, "lh");
        issue(1'b0, 3'b101, 32'h102, 32'h0, 5'd4, "lhu");
        issue(1'b0, 3'b000, 32'h100, 32'h0, 5'd5, "lb0");

        // Sub-word store then word load of the merged word.
        issue(1'b1, 3'b000, 32'h101, 32'h0000_005A, 5'd0, "sb");
        issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd6, "lw_sb");

        // SW followed immediately by a load of the same word.
        issue(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 5'd0, "sw");
        issue(1'b0, 3'b010, 32'h104, 32'h0, 5'd7, "lw_sw");

        // Faults do not stall and do not touch memory.
        issue(1'b0, 3'b010, 32'h102, 32'h0, 5'd8, "lw_mis");
        issue(1'b1, 3'b001, 32'h101, 32'h1234, 5'd0, "sh_mis");
        issue(1'b0, 3'b011, 32'h100, 32'h0, 5'd9, "f3_011");
        issue(1'b1, 3'b100, 32'h108, 32'h77, 5'd0, "sbu_ill");
        issue(1'b0, 3'b111, 32'h10C, 32'h0, 5'd10, "f3_111");
        issue(1'b0, 3'b101, 32'h103, 32'h0, 5'd11, "lhu_mis");
        issue(1'b0, 3'b010, 32'h108, 32'h0, 5'd12, "lw_after_f");

        // Alternating load / sub-word store stream.
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, 3'b010, 32'h110, 32'h0, 5'(13 + i), "strm_lw");
            if (i % 2 == 1)
                issue(1'b1, 3'b001, 32'h112, $urandom, 5'd0, "strm_sh");
            else
                issue(1'b1, 3'b000, 32'h110 + 32'(i % 4), $urandom, 5'd0, "strm_sb");
        end
        issue(1'b0, 3'b010, 32'h110, 32'h0, 5'd20, "strm_final");
        issue(1'b0, 3'b000, 32'h104, 32'h0, 5'd21, "lb_pre_rst");

        // Reset during MERGE abandons the pending sub-word write.
        valid_i = 1'b1; is_store_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h102;
        wdata_i = 32'h0000_1234; rd_i = 5'd0;
        @(negedge clk_i);
        chk("rmw_rst_accept", 32'(ready_o), 32'h1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        rst_ni  = 1'b0;
        @(negedge clk_i);
        chk("rmw_rst_wr_en", 32'(dccm_wr_en_o), 32'h0);
        chk("rmw_rst_rd_en", 32'(dccm_rd_en_o), 32'h0);
        chk("rmw_rst_wb_we", 32'(wb_we_o), 32'h0);
        chk("rmw_rst_wb_rd", 32'(wb_rd_o), 32'h0);
        chk("rmw_rst_wb_data", wb_data_o, 32'h0);
        chk("rmw_rst_fault", 32'(fault_o), 32'h0);
        chk("rmw_rst_fault_addr", fault_addr_o, 32'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rmw_rst_ready", 32'(ready_o), 32'h1);
        chk("rmw_rst_mem", dccm[64], ref_mem[64]);
        @(posedge clk_i); #1;
        issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd22, "lw_post_rst");

        repeat (3) @(negedge clk_i);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        chk("mem_0x100", dccm[64], ref_mem[64]);
        chk("mem_0x104", dccm[65], ref_mem[65]);
        chk("mem_0x110", dccm[68], ref_mem[68]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
